cam_line_capture: RTL and testbench
===================================

# cam_line_capture

Single-line camera capture buffer for the UDP streaming path (`line_buffer`). On a trigger it grabs one full active line of RGB565 pixels from a packed camera bus into on-chip RAM, tagged with its row number. It then presents the line to a downstream reader as a first-word-fall-through stream. Two instances sit under the camera-swap arbiter, which triggers them alternately and muxes their read ports.

## Interface
- `H_ACT`, default 1280: pixels per active line; also the capture and read length. Range 1..2048.
- `V_ACT`, default 720: active rows per frame; row target wraps at `V_ACT`-1. Range 1..2048.

Ports:
- `rclk`  in  1  sole clock; capture and read both run on it.
- `rstn`  in  1  asynchronous, active-low reset.
- `cam_pack`  in  49  packed camera bus, synchronous to `rclk`, field layout:
  - [15:0] pixel (RGB565)
  - [16] de
  - [17] href
  - [18] vsync
  - [29:19] x
  - [40:30] y
  - [48:41] reserved, ignored.
- `trig`  in  1  level capture request.
- `busy`  out  1  high from trigger acceptance until the last word is read.
- `aquire`  out  1  complete line held and readable.
- `read_en`  in  1  pop one word.
- `cam_data`  out  16  current word; valid while `aquire`=1.
- `cam_row`  out  11  row index of the held line.
- `error`  out  1  protocol/capture fault flag.

## Operation
Internal state:
- `tgt_row`: 11-bit target row, reset 0.
- Write pointer and read pointer, 11 bits each.
- RAM of `H_ACT` x 16.

States:
- **IDLE**
  - `busy`=0.
  - `trig`=1 -> WAIT_LINE.
  - `trig` is sampled only in IDLE and ignored elsewhere.
  - If `trig` is still high on return to IDLE, a new capture starts.
- **WAIT_LINE**
  - Wait for a `de` 0->1 edge with `y`==`tgt_row`.
  - On that edge, write the first pixel at address 0 -> CAPTURE.
- **CAPTURE**
  - Write `pixel` at the write pointer on every `de`=1 cycle.
  - After `H_ACT` pixels: latch `cam_row`=`tgt_row`, reset the read pointer -> READY.
  - `de` falls before `H_ACT` pixels, or `vsync` rises: set error -> IDLE. `tgt_row` is unchanged.
- **READY**
  - `aquire`=1 and `cam_data`=RAM[read pointer].
  - Each `read_en` advances the read pointer.
  - The `H_ACT`-th `read_en` -> IDLE and `tgt_row` increments. It wraps from `V_ACT`-1 to 0.

Error sources:
- `read_en` asserted while `aquire`=0.
- Short line or mid-line `vsync` (above).
- Extra pixels on the captured line are ignored. They do not raise error.

Reset values: `busy`=0, `aquire`=0, `cam_data`=0, `cam_row`=0, `error`=0, state IDLE.
- Reset mid-operation aborts immediately.
- Held RAM contents become don't-care.

## Timing
- `trig` high in IDLE at cycle N -> `busy`=1 at N+1.
- Last (`H_ACT`-th) pixel written at cycle M -> `aquire`=1 and `cam_data`=word 0 at M+1.
  - Requires registered RAM with prefetch of address 0.
- `read_en` at cycle K -> `cam_data` shows the next word at K+1.
  - `read_en` may be held continuously, one word per cycle.
- `H_ACT`-th `read_en` at cycle K -> `aquire`=0 and `busy`=0 at K+1.
- `cam_row` is stable from `aquire` rise until the next capture completes.

## Configuration
- `LINE_BUFFER_STICKY_ERR_EN` defined: `error` latches at 1 until `rstn` is asserted.
- Not defined: `error` is a one-cycle pulse, asserted the cycle after each fault event.

## Test plan
- Reset, `trig` held 1 for 2 cycles, row 0 fed as pixel = x (`H_ACT`=8):
  - `busy` rises one cycle after `trig`.
  - `aquire` rises the cycle after x=7.
  - `read_en` ×8 returns 0..7.
  - `cam_row`=0.
  - `busy` is 0 after the 8th read.
- Second trigger with rows 0..3 streamed: the row-1 line is captured and `cam_row`=1. Repeat until `tgt_row` = `V_ACT`-1, then the next capture targets row 0.
- Target row cut short (`de` falls after 5 of 8 pixels): `error`=1, `busy`=0, no `aquire`.
  - Retrigger captures the same row.
- `read_en` pulsed in IDLE: `error`=1 (sticky with macro defined, one-cycle pulse without).
- `trig` held high continuously: back-to-back captures of consecutive rows. `busy` drops for exactly one cycle between them.
- `rstn` asserted in READY mid-read: all outputs 0 immediately, and the next capture targets row 0.

Source files
------------

// File: rtl/cam_line_capture.sv
// cam_line_capture: on trigger, grabs one active RGB565 line into RAM and replays it as an FWFT stream.
// Optional LINE_BUFFER_STICKY_ERR_EN: error latches until reset instead of pulsing for one cycle.

module cam_line_capture #(
    parameter int H_ACT = 1280,
    parameter int V_ACT = 720
) (
    input  logic        rclk,
    input  logic        rstn,
    input  logic [48:0] cam_pack,
    input  logic        trig,
    output logic        busy,
    output logic        aquire,
    input  logic        read_en,
    output logic [15:0] cam_data,
    output logic [10:0] cam_row,
    output logic        error
);

    localparam int          AW       = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam logic [10:0] PIX_LAST = 11'(H_ACT - 1);
    localparam logic [10:0] ROW_LAST = 11'(V_ACT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_LINE,
        S_CAPTURE,
        S_READY
    } state_t;

    state_t      r_state;
    logic [10:0] r_tgt_row;
    logic [10:0] r_wptr;
    logic [10:0] r_rptr;
    logic        r_de_d;
    logic        r_vs_d;
    logic        r_busy;
    logic        r_aquire;
    logic        r_error;
    logic [15:0] r_cam_data;
    logic [10:0] r_cam_row;
    logic [15:0] r_mem [0:H_ACT-1];

    logic [15:0]   w_pixel;
    logic          w_de;
    logic          w_vs;
    logic [10:0]   w_y;
    logic          w_unused;
    logic          w_de_rise;
    logic          w_vs_rise;
    logic          w_start;
    logic          w_cap_abort;
    logic          w_we;
    logic [10:0]   w_waddr_full;
    logic [10:0]   w_raddr_full;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_raddr;
    logic          w_done;
    logic          w_pop;
    logic          w_pop_last;
    logic [15:0]   w_rword;
    logic          w_fault;

    assign w_pixel  = cam_pack[15:0];
    assign w_de     = cam_pack[16];
    assign w_vs     = cam_pack[18];
    assign w_y      = cam_pack[40:30];
    assign w_unused = &{1'b0, cam_pack[48:41], cam_pack[29:19], cam_pack[17]};

    assign w_de_rise   = w_de & ~r_de_d;
    assign w_vs_rise   = w_vs & ~r_vs_d;
    assign w_start     = (r_state == S_WAIT_LINE) && w_de_rise && (w_y == r_tgt_row);
    assign w_cap_abort = (r_state == S_CAPTURE) && (!w_de || w_vs_rise);
    assign w_we        = w_start || ((r_state == S_CAPTURE) && !w_cap_abort);

    assign w_waddr_full = (r_state == S_CAPTURE) ? r_wptr : 11'd0;
    assign w_done       = w_we && (w_waddr_full == PIX_LAST);

    assign w_pop        = (r_state == S_READY) && read_en;
    assign w_pop_last   = w_pop && (r_rptr == PIX_LAST);
    // The read port always prefetches the word that becomes visible after this edge.
    assign w_raddr_full = (w_pop && !w_pop_last) ? (r_rptr + 11'd1) : 11'd0;

    assign w_waddr = AW'(w_waddr_full);
    assign w_raddr = AW'(w_raddr_full);
    assign w_rword = (w_we && (w_waddr == w_raddr)) ? w_pixel : r_mem[w_raddr];

    assign w_fault = w_cap_abort || (read_en && !r_aquire);

    always_ff @(posedge rclk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_pixel;
        end
    end

    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_tgt_row  <= 11'd0;
            r_wptr     <= 11'd0;
            r_rptr     <= 11'd0;
            r_de_d     <= 1'b0;
            r_vs_d     <= 1'b0;
            r_busy     <= 1'b0;
            r_aquire   <= 1'b0;
            r_error    <= 1'b0;
            r_cam_data <= 16'd0;
            r_cam_row  <= 11'd0;
        end else begin
            r_de_d <= w_de;
            r_vs_d <= w_vs;
`ifdef LINE_BUFFER_STICKY_ERR_EN
            r_error <= r_error | w_fault;
`else
            r_error <= w_fault;
`endif
            case (r_state)
                S_IDLE: begin
                    if (trig) begin
                        r_state <= S_WAIT_LINE;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT_LINE: begin
                    if (w_start) begin
                        r_wptr  <= 11'd1;
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (w_cap_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_wptr <= r_wptr + 11'd1;
                    end
                end
                S_READY: begin
                    if (w_pop) begin
                        r_cam_data <= w_rword;
                        if (w_pop_last) begin
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                            r_aquire  <= 1'b0;
                            r_tgt_row <= (r_tgt_row == ROW_LAST) ? 11'd0 : (r_tgt_row + 11'd1);
                        end else begin
                            r_rptr <= r_rptr + 11'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Completing the line overrides the per-state updates above (also covers one-pixel lines).
            if (w_done) begin
                r_state    <= S_READY;
                r_aquire   <= 1'b1;
                r_cam_row  <= r_tgt_row;
                r_rptr     <= 11'd0;
                r_cam_data <= w_rword;
            end
        end
    end

    assign busy     = r_busy;
    assign aquire   = r_aquire;
    assign cam_data = r_cam_data;
    assign cam_row  = r_cam_row;
    assign error    = r_error;

endmodule

// File: tb/tb_cam_line_capture.sv
// Self-checking bench for cam_line_capture: streams randomized camera frames and
// compares the captured/replayed line against a row-level model of what should be held.

module tb_cam_line_capture;

    localparam int H = 8;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [48:0] cam_pack;
    logic        trig;
    logic        read_en;
    logic        busy;
    logic        aquire;
    logic [15:0] cam_data;
    logic [10:0] cam_row;
    logic        error;

    always #5 clk = ~clk;

    cam_line_capture #(.H_ACT(H), .V_ACT(V)) dut (
        .rclk     (clk),
        .rstn     (rstn),
        .cam_pack (cam_pack),
        .trig     (trig),
        .busy     (busy),
        .aquire   (aquire),
        .read_en  (read_en),
        .cam_data (cam_data),
        .cam_row  (cam_row),
        .error    (error)
    );

    int          nChecks = 0;
    int          nPass   = 0;
    int          errBad  = 0;
    bit          sticky;
    bit          errHeld;
    bit          faultNow;
    int          mTgt;
    bit          armed;
    logic [15:0] expLine [H];

    // Every comparison goes through here so the pass/total counts stay in one place.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) begin
            nPass++;
        end else begin
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle and compare error against the model's expectation for that cycle.
    task automatic cyc();
        @(negedge clk);
        if (error !== (faultNow | errHeld)) errBad++;
        if (faultNow) begin
            errHeld  = sticky;
            faultNow = 1'b0;
        end
    endtask

    task automatic applyStimulus(input bit de, input bit vs, input int x, input int y, input logic [15:0] pix);
        cam_pack = {8'($urandom), 11'(y), 11'(x), vs, de, de, pix};
    endtask

    // One frame: vsync pulse, then V rows; the armed target row is tracked by the model.
    task automatic driveFrame(input int lineLen, input int shortRow, input int shortLen, input bit pixIsX);
        logic [15:0] pix;
        int          len;
        bit          isTgt;
        applyStimulus(1'b0, 1'b1, 0, 0, 16'd0);
        cyc();
        cyc();
        applyStimulus(1'b0, 1'b0, 0, 0, 16'd0);
        cyc();
        for (int r = 0; r < V; r++) begin
            len   = (r == shortRow) ? shortLen : lineLen;
            isTgt = armed && (r == mTgt);
            for (int i = 0; i < len; i++) begin
                pix = pixIsX ? 16'(i) : 16'($urandom);
                if (isTgt && i < H) expLine[i] = pix;
                applyStimulus(1'b1, 1'b0, i, r, pix);
                cyc();
                if (isTgt && i == H - 2) checkOutput("aquire_early", aquire, 0);
                if (isTgt && i == H - 1) begin
                    checkOutput("aquire_rise", aquire, 1);
                    checkOutput("word0_ready", cam_data, expLine[0]);
                    checkOutput("cam_row", cam_row, mTgt);
                    armed = 1'b0;
                end
            end
            applyStimulus(1'b0, 1'b0, 0, r, 16'd0);
            if (isTgt && len < H) faultNow = 1'b1;
            cyc();
            if (isTgt && len < H) begin
                checkOutput("short_err", error, 1);
                checkOutput("short_busy", busy, 0);
                checkOutput("short_aquire", aquire, 0);
                armed = 1'b0;
            end
            cyc();
        end
        checkOutput("err_trace_frame", errBad, 0);
        errBad = 0;
    endtask

    task automatic readLine(input int n, input bit dropTrig);
        for (int i = 0; i < n; i++) begin
            checkOutput("rd_data", cam_data, expLine[i]);
            if (i == 0) checkOutput("busy_ready", busy, 1);
            read_en = 1'b1;
            cyc();
        end
        read_en = 1'b0;
        if (dropTrig) trig = 1'b0;
        if (n == H) begin
            checkOutput("aquire_fall", aquire, 0);
            checkOutput("busy_fall", busy, 0);
            mTgt = (mTgt + 1) % V;
        end
        checkOutput("err_trace_read", errBad, 0);
        errBad = 0;
    endtask

    task automatic pulseTrig();
        trig = 1'b1;
        cyc();
        checkOutput("busy_rise", busy, 1);
        armed = 1'b1;
        trig  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "[TB] timeout");
    end

    initial begin
`ifdef LINE_BUFFER_STICKY_ERR_EN
        sticky = 1'b1;
`else
        sticky = 1'b0;
`endif
        rstn     = 1'b0;
        trig     = 1'b0;
        read_en  = 1'b0;
        errHeld  = 1'b0;
        faultNow = 1'b0;
        mTgt     = 0;
        armed    = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, 0, 16'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_aquire", aquire, 0);
        checkOutput("rst_cam_data", cam_data, 0);
        checkOutput("rst_cam_row", cam_row, 0);
        checkOutput("rst_error", error, 0);
        #2 rstn = 1'b1;
        cyc();

        // First capture: trig held two cycles, row 0 carries pixel = x.
        trig = 1'b1;
        cyc();
        checkOutput("busy_rise", busy, 1);
        armed = 1'b1;
        cyc();
        trig = 1'b0;
        driveFrame(H, -1, 0, 1'b1);
        readLine(H, 1'b0);
        checkOutput("cam_row_hold", cam_row, 0);

        // Consecutive single triggers walk rows 1..V-1 and wrap back to row 0.
        repeat (V) begin
            pulseTrig();
            driveFrame(H, -1, 0, 1'b0);
            readLine(H, 1'b0);
        end

        // Target row cut short, then the same row is captured on retrigger.
        pulseTrig();
        driveFrame(H, mTgt, 5, 1'b0);
        checkOutput("short_idle_busy", busy, 0);
        pulseTrig();
        driveFrame(H, -1, 0, 1'b0);
        readLine(H, 1'b0);

        // read_en with nothing held.
        read_en  = 1'b1;
        faultNow = 1'b1;
        cyc();
        checkOutput("idle_rd_err", error, 1);
        checkOutput("idle_rd_busy", busy, 0);
        read_en = 1'b0;
        cyc();
        checkOutput("idle_rd_err_after", error, sticky);

        // trig held high: back-to-back captures with a one-cycle busy gap.
        trig = 1'b1;
        cyc();
        checkOutput("busy_rise", busy, 1);
        armed = 1'b1;
        driveFrame(H, -1, 0, 1'b0);
        readLine(H, 1'b0);
        cyc();
        checkOutput("b2b_busy_again", busy, 1);
        armed = 1'b1;
        driveFrame(H, -1, 0, 1'b0);
        readLine(H, 1'b1);

        // Lines longer than H_ACT: the extra pixels are ignored.
        pulseTrig();
        driveFrame(H + 3, -1, 0, 1'b0);
        readLine(H, 1'b0);

        // Reset in the middle of reading.
        pulseTrig();
        driveFrame(H, -1, 0, 1'b0);
        readLine(3, 1'b0);
        #2 rstn = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_aquire", aquire, 0);
        checkOutput("midrst_cam_data", cam_data, 0);
        checkOutput("midrst_cam_row", cam_row, 0);
        checkOutput("midrst_error", error, 0);
        errHeld  = 1'b0;
        faultNow = 1'b0;
        mTgt     = 0;
        armed    = 1'b0;
        #1 rstn = 1'b1;
        pulseTrig();
        driveFrame(H, -1, 0, 1'b0);
        readLine(H, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
